// File: rtl/pwm_peripheral_if.sv
// ============================================================================
// Module      : pwm_peripheral_if
// Description : Register-side bundle of the PWM peripheral (enables, duty, outputs)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pwm_peripheral_if;
    logic [7:0]  en_reg_out_7_0;
    logic [7:0]  en_reg_out_15_8;
    logic [7:0]  en_reg_pwm_7_0;
    logic [7:0]  en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic [15:0] out;
    logic        period_start;

    modport master (
        output en_reg_out_7_0,
        output en_reg_out_15_8,
        output en_reg_pwm_7_0,
        output en_reg_pwm_15_8,
        output pwm_duty_cycle,
        input  out,
        input  period_start
    );

    modport slave (
        input  en_reg_out_7_0,
        input  en_reg_out_15_8,
        input  en_reg_pwm_7_0,
        input  en_reg_pwm_15_8,
        input  pwm_duty_cycle,
        output out,
        output period_start
    );
endinterface

`default_nettype wire

// File: rtl/pwm_peripheral.sv
// ============================================================================
// Module      : pwm_peripheral
// Description : 16-channel PWM with shared, period-synchronous duty cycle
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_peripheral #(
    parameter int unsigned PRESCALE = 13
) (
    input  wire logic         clk,
    input  wire logic         rst,
    pwm_peripheral_if.slave   regs_if
);

    localparam logic [15:0] c_presc_last = 16'(PRESCALE - 1);

    logic [15:0] presc_q, presc_d;
    logic [7:0]  cnt_q,   cnt_d;
    logic [7:0]  duty_q,  duty_d;
    logic [15:0] out_q,   out_d;
    logic        ps_q,    ps_d;

    logic        w_tick;
    logic        w_wrap;
    logic        w_level;
    logic [15:0] w_en_out;
    logic [15:0] w_en_pwm;

    assign w_en_out = {regs_if.en_reg_out_15_8, regs_if.en_reg_out_7_0};
    assign w_en_pwm = {regs_if.en_reg_pwm_15_8, regs_if.en_reg_pwm_7_0};

    // The level is taken from next-state counter/duty so the first out update
    // of a new period lands on the same cycle as period_start.
    always_comb begin
        w_tick  = (presc_q == c_presc_last);
        w_wrap  = w_tick && (cnt_q == 8'hFF);
        presc_d = w_tick ? 16'd0 : presc_q + 16'd1;
        cnt_d   = w_tick ? cnt_q + 8'd1 : cnt_q;
        duty_d  = w_wrap ? regs_if.pwm_duty_cycle : duty_q;
        w_level = (duty_d == 8'hFF) || (cnt_d < duty_d);
        out_d   = w_en_out & (~w_en_pwm | {16{w_level}});
        ps_d    = w_wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= 16'd0;
            cnt_q   <= 8'd0;
            duty_q  <= 8'd0;
            out_q   <= 16'd0;
            ps_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            duty_q  <= duty_d;
            out_q   <= out_d;
            ps_q    <= ps_d;
        end
    end

    assign regs_if.out          = out_q;
    assign regs_if.period_start = ps_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_peripheral.sv
// ============================================================================
// Module      : tb_pwm_peripheral
// Description : Scoreboard bench for pwm_peripheral using a closed-form model
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_peripheral;

    localparam int c_presc  = 13;
    localparam int c_period = 256 * c_presc;

    logic clk = 1'b0;
    logic rst = 1'b0;

    pwm_peripheral_if regs_if ();

    pwm_peripheral #(.PRESCALE(c_presc)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .regs_if (regs_if.slave)
    );

    always #5 clk = ~clk;

    int          r_errors = 0;
    int          r_checks = 0;
    int          r_n      = 0;
    int          r_pbase  = 0;
    logic [7:0]  r_shadow = 8'h00;
    logic [16:0] r_exp_q[$];
    int          r_hi[10];
    int          r_ps[10];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_checks++;
        if (got !== exp) begin
            r_errors++;
            $display("FAIL %s: got %h expected %h (n=%0d)", tag, got, exp, r_n);
        end
    endtask

    task automatic set_inputs(input logic [15:0] en_out, input logic [15:0] en_pwm, input logic [7:0] duty);
        regs_if.en_reg_out_7_0  = en_out[7:0];
        regs_if.en_reg_out_15_8 = en_out[15:8];
        regs_if.en_reg_pwm_7_0  = en_pwm[7:0];
        regs_if.en_reg_pwm_15_8 = en_pwm[15:8];
        regs_if.pwm_duty_cycle  = duty;
    endtask

    // Expected state after edge n since reset release is closed-form:
    // counter = (n / PRESCALE) mod 256, duty reloads on multiples of the period.
    task automatic step();
        logic [15:0] en_out;
        logic [15:0] en_pwm;
        logic [7:0]  cnt;
        logic        level;
        logic [16:0] exp;
        logic [16:0] got;
        int          p;
        r_n++;
        if (r_n % c_period == 0)
            r_shadow = regs_if.pwm_duty_cycle;
        cnt    = 8'((r_n / c_presc) % 256);
        level  = (r_shadow == 8'hFF) || (cnt < r_shadow);
        en_out = {regs_if.en_reg_out_15_8, regs_if.en_reg_out_7_0};
        en_pwm = {regs_if.en_reg_pwm_15_8, regs_if.en_reg_pwm_7_0};
        exp    = {(r_n % c_period == 0), en_out & (~en_pwm | {16{level}})};
        r_exp_q.push_back(exp);
        @(posedge clk);
        #1;
        got = {regs_if.period_start, regs_if.out};
        check("cycle", 32'(got), 32'(r_exp_q.pop_front()));
        p = r_pbase + r_n / c_period;
        if (p < 10) begin
            r_hi[p] += int'(regs_if.out[0]);
            r_ps[p] += int'(regs_if.period_start);
        end
    endtask

    task automatic run_to(input int target);
        while (r_n < target) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got n=%0d required completion", r_n);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 10; i++) begin
            r_hi[i] = 0;
            r_ps[i] = 0;
        end
        set_inputs(16'hFFFF, 16'hFFFF, 8'hFF);
        #1 rst = 1'b1;
        #1 check("rst_async", 32'({regs_if.period_start, regs_if.out}), 32'h0);
        repeat (3) begin
            @(posedge clk);
            #1 check("rst_hold", 32'({regs_if.period_start, regs_if.out}), 32'h0);
        end
        rst = 1'b0;

        // Static enable, non-PWM channel 0 for two periods
        set_inputs(16'h0001, 16'h0000, 8'h80);
        run_to(2 * c_period - 1);

        // All channels PWM at 50 %, mid-period duty write must be ignored
        set_inputs(16'hFFFF, 16'hFFFF, 8'h80);
        run_to(2 * c_period);
        regs_if.pwm_duty_cycle = 8'h00;
        run_to(3 * c_period);
        regs_if.pwm_duty_cycle = 8'hFF;
        run_to(4 * c_period);
        regs_if.pwm_duty_cycle = 8'h40;
        run_to(5 * c_period + 16 * c_presc - 1);
        regs_if.pwm_duty_cycle = 8'hC0;
        run_to(6 * c_period);
        regs_if.pwm_duty_cycle = 8'h80;
        run_to(7 * c_period + 8'h50 * c_presc);

        // Reset in the middle of a high phase
        check("pre_rst_high", 32'(regs_if.out), 32'hFFFF);
        #2 rst = 1'b1;
        #1 check("rst_mid", 32'({regs_if.period_start, regs_if.out}), 32'h0);
        repeat (3) begin
            @(posedge clk);
            #1 check("rst_mid_hold", 32'({regs_if.period_start, regs_if.out}), 32'h0);
        end
        rst      = 1'b0;
        r_n      = 0;
        r_shadow = 8'h00;
        r_pbase  = 8;
        run_to(2 * c_period - 1);

        check("hi_p0_static", 32'(r_hi[0]), 32'(c_period - 1));
        check("hi_p1_static", 32'(r_hi[1]), 32'(c_period));
        check("hi_p2_duty80", 32'(r_hi[2]), 32'd1664);
        check("hi_p3_duty00", 32'(r_hi[3]), 32'd0);
        check("hi_p4_dutyFF", 32'(r_hi[4]), 32'(c_period));
        check("hi_p5_duty40", 32'(r_hi[5]), 32'(64 * c_presc));
        check("hi_p6_dutyC0", 32'(r_hi[6]), 32'(192 * c_presc));
        check("hi_p8_postrst", 32'(r_hi[8]), 32'd0);
        check("hi_p9_postrst", 32'(r_hi[9]), 32'(128 * c_presc));
        check("ps_p0", 32'(r_ps[0]), 32'd0);
        for (int i = 1; i < 7; i++)
            check($sformatf("ps_p%0d", i), 32'(r_ps[i]), 32'd1);
        check("ps_p8", 32'(r_ps[8]), 32'd0);
        check("ps_p9", 32'(r_ps[9]), 32'd1);
        check("queue_empty", 32'(r_exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", r_errors, r_checks);
        $finish;
    end

endmodule

`default_nettype wire
